// File: rtl/mem_access_if.sv
// Pipeline-request, response and memory-bus signals of mem_access_unit.
// Define MEM_ACCESS_TIMEOUT_EN to add the rsp_timeout response flag.
interface mem_access_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // req_valid must hold its payload until then. rsp_valid is a one-cycle pulse
    // with no back-pressure, and bus_ack completes the active bus_req in that cycle.
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_size;
    logic              req_sign;
    logic [DATA_W-1:0] req_wdata;

    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_exc;
    logic              rsp_exc_store;
`ifdef MEM_ACCESS_TIMEOUT_EN
    logic              rsp_timeout;
`endif

    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W/8-1:0] bus_be;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_ack;
    logic [DATA_W-1:0] bus_rdata;

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_sign, req_wdata,
        input  bus_ack, bus_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_exc, rsp_exc_store,
`ifdef MEM_ACCESS_TIMEOUT_EN
        output rsp_timeout,
`endif
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata
    );

    modport master (
        output req_valid, req_we, req_addr, req_size, req_sign, req_wdata,
        output bus_ack, bus_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_exc, rsp_exc_store,
`ifdef MEM_ACCESS_TIMEOUT_EN
        input  rsp_timeout,
`endif
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// Handshaked M-stage load/store unit: lane alignment, byte enables, load extension.
// Define MEM_ACCESS_TIMEOUT_EN to abort bus waits after TIMEOUT_CYC cycles.
module mem_access_unit #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic         clk,
    input  logic         reset_n,
    mem_access_if.slave  mif,
    output logic [1:0]   dbg_state
);
    localparam int NB = DATA_W / 8;
    localparam int OB = $clog2(NB);

    typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2} state_t;

    state_t            state;
    logic              we_q;
    logic [OB-1:0]     off_q;
    logic [1:0]        size_q;
    logic              sign_q;

    logic              ready_q, bus_req_q, bus_we_q, rsp_valid_q, rsp_exc_q, rsp_exc_store_q;
    logic [ADDR_W-1:0] bus_addr_q;
    logic [NB-1:0]     bus_be_q;
    logic [DATA_W-1:0] bus_wdata_q, rsp_rdata_q;
`ifdef MEM_ACCESS_TIMEOUT_EN
    logic [15:0]       wait_cnt;
    logic              rsp_timeout_q;
`endif

    logic [OB-1:0]     req_off;
    logic              req_misaligned;
    logic [NB-1:0]     req_be;
    logic [DATA_W-1:0] req_wdata_sh;
    logic [DATA_W-1:0] rd_shifted;
    logic [DATA_W-1:0] load_data;
    logic              fill;
    int                nbytes, nb_q;

    always_comb begin
        req_off        = mif.req_addr[OB-1:0];
        nbytes         = 1 << mif.req_size;
        req_misaligned = (nbytes > NB) || ((int'(req_off) & (nbytes - 1)) != 0);
        for (int i = 0; i < NB; i++)
            req_be[i] = (i >= int'(req_off)) && (i < int'(req_off) + nbytes);
        req_wdata_sh   = mif.req_wdata << {req_off, 3'b000};
    end

    // Load extraction: move the addressed bytes to lane 0, then fill the rest.
    always_comb begin
        rd_shifted = mif.bus_rdata >> {off_q, 3'b000};
        nb_q       = 1 << size_q;
        if (nb_q > NB) nb_q = NB;
        fill = 1'b0;
        for (int i = 0; i < NB; i++)
            if (i == nb_q - 1) fill = sign_q & rd_shifted[8*i+7];
        load_data = '0;
        for (int i = 0; i < NB; i++)
            load_data[8*i +: 8] = (i < nb_q) ? rd_shifted[8*i +: 8] : {8{fill}};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            we_q            <= 1'b0;
            off_q           <= '0;
            size_q          <= 2'd0;
            sign_q          <= 1'b0;
            ready_q         <= 1'b1;
            bus_req_q       <= 1'b0;
            bus_we_q        <= 1'b0;
            bus_addr_q      <= '0;
            bus_be_q        <= '0;
            bus_wdata_q     <= '0;
            rsp_valid_q     <= 1'b0;
            rsp_rdata_q     <= '0;
            rsp_exc_q       <= 1'b0;
            rsp_exc_store_q <= 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
            wait_cnt        <= 16'd0;
            rsp_timeout_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (mif.req_valid) begin
                    we_q    <= mif.req_we;
                    off_q   <= req_off;
                    size_q  <= mif.req_size;
                    sign_q  <= mif.req_sign;
                    ready_q <= 1'b0;
                    if (req_misaligned) begin
                        state           <= RESP;
                        rsp_valid_q     <= 1'b1;
                        rsp_exc_q       <= 1'b1;
                        rsp_exc_store_q <= mif.req_we;
                    end else begin
                        state       <= BUS;
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= mif.req_we;
                        bus_addr_q  <= {mif.req_addr[ADDR_W-1:OB], {OB{1'b0}}};
                        bus_be_q    <= req_be;
                        bus_wdata_q <= req_wdata_sh;
`ifdef MEM_ACCESS_TIMEOUT_EN
                        wait_cnt    <= 16'd0;
`endif
                    end
                end
                BUS: begin
                    if (mif.bus_ack) begin
                        state       <= RESP;
                        bus_req_q   <= 1'b0;
                        bus_we_q    <= 1'b0;
                        bus_be_q    <= '0;
                        bus_wdata_q <= '0;
                        bus_addr_q  <= '0;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= we_q ? '0 : load_data;
                    end
`ifdef MEM_ACCESS_TIMEOUT_EN
                    else if (wait_cnt == 16'(TIMEOUT_CYC - 1)) begin
                        state           <= RESP;
                        bus_req_q       <= 1'b0;
                        bus_we_q        <= 1'b0;
                        bus_be_q        <= '0;
                        bus_wdata_q     <= '0;
                        bus_addr_q      <= '0;
                        rsp_valid_q     <= 1'b1;
                        rsp_exc_q       <= 1'b1;
                        rsp_exc_store_q <= we_q;
                        rsp_timeout_q   <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
`endif
                end
                RESP: begin
                    state           <= IDLE;
                    ready_q         <= 1'b1;
                    rsp_valid_q     <= 1'b0;
                    rsp_rdata_q     <= '0;
                    rsp_exc_q       <= 1'b0;
                    rsp_exc_store_q <= 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
                    rsp_timeout_q   <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mif.req_ready     = ready_q;
    assign mif.rsp_valid     = rsp_valid_q;
    assign mif.rsp_rdata     = rsp_rdata_q;
    assign mif.rsp_exc       = rsp_exc_q;
    assign mif.rsp_exc_store = rsp_exc_store_q;
`ifdef MEM_ACCESS_TIMEOUT_EN
    assign mif.rsp_timeout   = rsp_timeout_q;
`endif
    assign mif.bus_req       = bus_req_q;
    assign mif.bus_we        = bus_we_q;
    assign mif.bus_addr      = bus_addr_q;
    assign mif.bus_be        = bus_be_q;
    assign mif.bus_wdata     = bus_wdata_q;
    assign dbg_state         = state;
endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized and directed bench for mem_access_unit against a byte-level reference model.
// Exercises the MEM_ACCESS_TIMEOUT_EN abort path when that macro is defined.
module tb_mem_access_unit;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int NB     = DATA_W / 8;
    localparam int W      = DATA_W + 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    mem_access_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) mif ();
    logic [1:0] dbg_state;

    mem_access_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT_CYC(4)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .mif      (mif),
        .dbg_state(dbg_state)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Bus responder: word memory, acks after waits_cfg wait cycles
    logic [31:0] mem [0:15];
    int   waits_cfg = 0;
    int   bcnt = 0;
    logic resp_en = 1'b1;
    logic resp_ack = 1'b0;
    logic stray_ack = 1'b0;
    assign mif.bus_ack   = resp_ack | stray_ack;
    assign mif.bus_rdata = mem[mif.bus_addr[5:2]];

    always @(negedge clk) begin
        if (mif.bus_req && resp_en) begin
            bcnt++;
            resp_ack = (bcnt > waits_cfg);
        end else begin
            bcnt = 0;
            resp_ack = 1'b0;
        end
    end

    logic [W-1:0] exp_q[$];

    function automatic void model(input logic we, input logic [31:0] addr, input logic [1:0] size,
                                  input logic sign, input logic [31:0] wdata,
                                  output logic exc, output logic [3:0] be,
                                  output logic [31:0] bw, output logic [31:0] rd);
        int nb;
        int off;
        longint unsigned v, m;
        nb  = 1 << size;
        off = int'(addr[1:0]);
        exc = (nb > NB) || ((off % nb) != 0);
        be = '0; bw = '0; rd = '0;
        if (!exc) begin
            be = 4'(((1 << nb) - 1) << off);
            bw = 32'(longint'(wdata) << (8 * off));
            if (!we) begin
                v = longint'(mem[addr[5:2]]) >> (8 * off);
                m = (64'd1 << (8 * nb)) - 64'd1;
                v = v & m;
                if (sign && v[8*nb-1]) v = v | ~m;
                rd = v[31:0];
            end
        end
    endfunction

    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [1:0] size,
                           input logic sign, input logic [31:0] wdata, input int waits);
        logic exc;
        logic [3:0] be;
        logic [31:0] bw, rd;
        logic [W-1:0] exp;
        int lat, n;
        bit done, seen;
        model(we, addr, size, sign, wdata, exc, be, bw, rd);
        exp_q.push_back({exc, exc & we, rd});
        waits_cfg = waits;
        n = 0;
        while (!mif.req_ready && n < 50) begin @(negedge clk); n++; end
        check("ready_before_req", 64'(mif.req_ready), 64'd1);
        mif.req_valid = 1'b1; mif.req_we = we; mif.req_addr = addr;
        mif.req_size = size; mif.req_sign = sign; mif.req_wdata = wdata;
        @(posedge clk);
        @(negedge clk);
        mif.req_valid = 1'b0;
        lat = 1; done = 0; seen = 0;
        while (!done && lat < 60) begin
            if (mif.bus_req) begin
                seen = 1;
                check("bus_addr", 64'(mif.bus_addr), 64'(addr & 32'hFFFF_FFFC));
                check("bus_be", 64'(mif.bus_be), 64'(be));
                check("bus_wdata", 64'(mif.bus_wdata), 64'(bw));
                check("bus_we", 64'(mif.bus_we), 64'(we));
            end
            if (mif.rsp_valid) begin
                done = 1;
                exp = exp_q.pop_front();
                check("rsp_latency", 64'(lat), exc ? 64'd1 : 64'(waits + 2));
                check("rsp_fields", 64'({mif.rsp_exc, mif.rsp_exc_store, mif.rsp_rdata}), 64'(exp));
`ifdef MEM_ACCESS_TIMEOUT_EN
                check("rsp_timeout_flag", 64'(mif.rsp_timeout), 64'd0);
`endif
            end else begin
                check("rsp_quiet", 64'({mif.rsp_exc, mif.rsp_exc_store, mif.rsp_rdata}), 64'd0);
                @(negedge clk);
                lat++;
            end
        end
        if (!done) check("rsp_wait_bound", 64'd0, 64'd1);
        check("bus_issued", 64'(seen), 64'(!exc));
    endtask

    initial begin
        int nacc, nrsp, lat, cnt;
        int acc_c [2];
        bit will_acc;
        mif.req_valid = 1'b0; mif.req_we = 1'b0; mif.req_addr = '0;
        mif.req_size = 2'd0; mif.req_sign = 1'b0; mif.req_wdata = '0;
        for (int i = 0; i < 16; i++) mem[i] = $urandom;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(mif.req_ready), 64'd1);
        check("rst_outputs", 64'({mif.bus_req, mif.bus_we, mif.bus_be, mif.rsp_valid, mif.rsp_exc,
                                   mif.rsp_exc_store}), 64'd0);
        check("rst_bus_addr", 64'(mif.bus_addr), 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Directed cases
        mem[0] = 32'h12F4_5678;
        run_txn(1'b1, 32'h0000_1003, 2'd0, 1'b0, 32'h0000_00A5, 0);
        run_txn(1'b0, 32'h0000_2002, 2'd0, 1'b1, 32'h0, 3);
        run_txn(1'b0, 32'h0000_2002, 2'd0, 1'b0, 32'h0, 3);
        run_txn(1'b0, 32'h0000_2002, 2'd1, 1'b1, 32'h0, 1);
        run_txn(1'b0, 32'h0000_2001, 2'd1, 1'b0, 32'h0, 0);
        run_txn(1'b1, 32'h0000_2002, 2'd2, 1'b0, 32'hDEAD_BEEF, 0);
        run_txn(1'b0, 32'h0000_2000, 2'd3, 1'b0, 32'h0, 0);
        run_txn(1'b0, 32'h0000_2000, 2'd2, 1'b1, 32'h0, 2);

        // Randomized traffic
        for (int k = 0; k < 40; k++)
            run_txn(1'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3));

        // Back-to-back loads with req_valid held
        @(negedge clk);
        mem[0] = $urandom; mem[1] = $urandom; waits_cfg = 0;
        mif.req_valid = 1'b1; mif.req_we = 1'b0; mif.req_addr = 32'h0;
        mif.req_size = 2'd2; mif.req_sign = 1'b0;
        nacc = 0; nrsp = 0; acc_c[0] = 0; acc_c[1] = 0;
        for (int c = 0; c < 20 && nrsp < 2; c++) begin
            will_acc = mif.req_valid && mif.req_ready;
            if (mif.rsp_valid) begin
                check("b2b_rdata", 64'(mif.rsp_rdata), 64'(mem[nrsp]));
                nrsp++;
            end
            @(posedge clk);
            @(negedge clk);
            if (will_acc && nacc < 2) begin
                acc_c[nacc] = c;
                nacc++;
                if (nacc == 1) mif.req_addr = 32'h4;
                else mif.req_valid = 1'b0;
            end
        end
        mif.req_valid = 1'b0;
        check("b2b_accepts", 64'(nacc), 64'd2);
        check("b2b_gap", 64'(acc_c[1] - acc_c[0]), 64'd3);
        check("b2b_responses", 64'(nrsp), 64'd2);

        // Reset during BUS
        repeat (2) @(negedge clk);
        waits_cfg = 30;
        mif.req_valid = 1'b1; mif.req_we = 1'b0; mif.req_addr = 32'h8; mif.req_size = 2'd2;
        @(posedge clk);
        @(negedge clk);
        mif.req_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_rst_bus_req", 64'(mif.bus_req), 64'd1);
        reset_n = 1'b0;
        #1;
        check("midrst_bus_req", 64'(mif.bus_req), 64'd0);
        check("midrst_ready", 64'(mif.req_ready), 64'd1);
        @(negedge clk);
        reset_n = 1'b1;
        stray_ack = 1'b1;
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            stray_ack = 1'b0;
            if (mif.rsp_valid || mif.bus_req) cnt++;
        end
        check("post_rst_silent", 64'(cnt), 64'd0);
        check("post_rst_state", 64'(dbg_state), 64'd0);
        waits_cfg = 0;

`ifdef MEM_ACCESS_TIMEOUT_EN
        // Load that never gets bus_ack aborts after 4 BUS cycles
        resp_en = 1'b0;
        mif.req_valid = 1'b1; mif.req_we = 1'b0; mif.req_addr = 32'hC; mif.req_size = 2'd2;
        @(posedge clk);
        @(negedge clk);
        mif.req_valid = 1'b0;
        lat = 1;
        while (!mif.rsp_valid && lat < 40) begin @(negedge clk); lat++; end
        check("to_latency", 64'(lat), 64'd5);
        check("to_fields", 64'({mif.rsp_exc, mif.rsp_exc_store, mif.rsp_timeout, mif.rsp_rdata}),
              64'({1'b1, 1'b0, 1'b1, 32'h0}));
        stray_ack = 1'b1;
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            stray_ack = 1'b0;
            if (mif.rsp_valid || mif.bus_req) cnt++;
        end
        check("to_late_ack", 64'(cnt), 64'd0);
        resp_en = 1'b1;
        run_txn(1'b1, 32'h0000_3004, 2'd2, 1'b0, 32'h1234_5678, 3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
